i2c_master_wr: RTL and testbench

Single-byte I2C write initiator: on a start request it generates START, sends a 7-bit slave address with R/W=0, checks the ACK, sends one data byte, checks the ACK, then generates STOP. It is the bus-master counterpart of the team's `i2c_slave` receiver and drives that block's `scl`/`sda_in` in system and bench. SCL is derived from `clk` by an internal divider. SDA is modelled open-drain as a separate output and input.

---
 rtl/i2c_master_wr_if.sv | 24 ++
 rtl/i2c_master_wr.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_wr.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_wr_if.sv
// Bus and handshake bundle for the single-byte I2C write initiator.
// The master modport is the initiator's view; the slave modport is the system/bench view.
interface i2c_master_wr_if;
    logic       start;
    logic [6:0] slave_addr;
    logic [7:0] wr_data;
    logic       sda_in;
    logic       scl;
    logic       sda_out;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [2:0] dbg_state;

    modport master (
        input  start, slave_addr, wr_data, sda_in,
        output scl, sda_out, busy, done, ack_err, dbg_state
    );

    modport slave (
        output start, slave_addr, wr_data, sda_in,
        input  scl, sda_out, busy, done, ack_err, dbg_state
    );
endinterface

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write initiator: START, address+W, ACK, data byte, ACK, STOP.
// Handshake: start is sampled only while busy=0 and done=0; done pulses for one cycle as busy falls.
module i2c_master_wr #(
    parameter int CLK_DIV = 125
) (
    input  logic               clk,
    input  logic               rst,
    i2c_master_wr_if.master    bus
);
    localparam int             DW      = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] ADDR  = 3'd2;
    localparam logic [2:0] ACK1  = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] ACK2  = 3'd5;
    localparam logic [2:0] STOP  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    q_q, q_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tick;
    logic [7:0]    addr_byte;

    assign tick = busy_q && (div_q == DIV_MAX);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        q_d       = q_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        scl_d     = 1'b1;
        sda_d     = 1'b1;
        addr_byte = 8'h00;

        if (busy_q) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end

        if (state_q == IDLE) begin
            // The done cycle itself is still closing the previous transfer.
            if (bus.start && !done_q) begin
                state_d = START;
                div_d   = '0;
                q_d     = 2'd0;
                bit_d   = 3'd7;
                addr_d  = bus.slave_addr;
                data_d  = bus.wr_data;
                busy_d  = 1'b1;
                err_d   = 1'b0;
            end
        end else if (tick) begin
            q_d = q_q + 2'd1;
            if ((state_q == ACK1 || state_q == ACK2) && q_q == 2'd2 && bus.sda_in) begin
                err_d = 1'b1;
            end
            if (q_q == 2'd3) begin
                case (state_q)
                    START: begin
                        state_d = ADDR;
                        bit_d   = 3'd7;
                    end
                    ADDR: begin
                        if (bit_q == 3'd0) state_d = ACK1;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    ACK1: begin
                        // err_q here holds the ACK1 sample taken at the end of q2.
                        state_d = err_q ? STOP : DATA;
                        bit_d   = 3'd7;
                    end
                    DATA: begin
                        if (bit_q == 3'd0) state_d = ACK2;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    ACK2: state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Line levels are registered from the next slot/phase so SCL and SDA never glitch.
        addr_byte = {addr_d, 1'b0};
        case (state_d)
            START: begin
                scl_d = 1'b1;
                sda_d = (q_d < 2'd2);
            end
            ADDR: begin
                scl_d = q_d[1];
                sda_d = addr_byte[bit_d];
            end
            DATA: begin
                scl_d = q_d[1];
                sda_d = data_d[bit_d];
            end
            ACK1, ACK2: begin
                scl_d = q_d[1];
                sda_d = 1'b1;
            end
            STOP: begin
                scl_d = q_d[1];
                sda_d = (q_d == 2'd3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            q_q     <= 2'd0;
            bit_q   <= 3'd7;
            addr_q  <= 7'd0;
            data_q  <= 8'd0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.scl       = scl_q;
    assign bus.sda_out   = sda_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ack_err   = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: slot/phase timeline model, wired-AND slave stub, directed and random transfers.
module tb_i2c_master_wr;
  localparam int CD   = 4;
  localparam int SLOT = 4 * CD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_pull = 1'b0;

  i2c_master_wr_if bus();
  assign bus.sda_in = bus.sda_out & ~slave_pull;

  i2c_master_wr #(.CLK_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Model: transaction timeline expressed as cycles elapsed since acceptance.
  bit         m_active, m_done, m_err, m_nack1, m_nack2;
  int         m_n, m_nslots;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  bit         next_nack1, next_nack2;
  bit         chk_en = 1'b0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  logic [31:0] cap_word;
  int         cap_cnt;
  logic       prev_scl = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
    m_n        = 0;
    slave_pull = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept();
    logic [7:0] ab;
    m_active = 1'b1;
    m_n      = 0;
    m_addr   = bus.slave_addr;
    m_data   = bus.wr_data;
    m_err    = 1'b0;
    m_nack1  = next_nack1;
    m_nack2  = next_nack2;
    m_nslots = m_nack1 ? 11 : 20;
    acc_cyc  = cyc;
    ab = {m_addr, 1'b0};
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
    exp_q.push_back(1'b1);
    if (!m_nack1) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(m_data[i]);
      exp_q.push_back(1'b1);
    end
    exp_q.push_back(1'b0);
  endtask

  task automatic model_edge(input logic st);
    if (m_active) begin
      m_n++;
      if (m_nack1 && m_n == 9 * SLOT + 3 * CD) m_err = 1'b1;
      if (!m_nack1 && m_nack2 && m_n == 18 * SLOT + 3 * CD) m_err = 1'b1;
      if (m_n == m_nslots * SLOT) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (st) begin
      model_accept();
    end
  endtask

  function automatic void exp_bus(output logic e_scl, output logic e_sda);
    int slot;
    int q;
    logic [7:0] ab;
    slot = m_n / SLOT;
    q    = (m_n / CD) % 4;
    ab   = {m_addr, 1'b0};
    e_scl = (q >= 2);
    e_sda = 1'b1;
    if (slot == 0) begin
      e_scl = 1'b1;
      e_sda = (q < 2);
    end else if (slot <= 8) begin
      e_sda = ab[8 - slot];
    end else if (slot == 9 || slot == 18) begin
      e_sda = 1'b1;
    end else if (slot == m_nslots - 1) begin
      e_sda = (q == 3);
    end else begin
      e_sda = m_data[17 - slot];
    end
  endfunction

  task automatic cycle(input logic st);
    int slot;
    bus.start = st;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else     model_edge(st);
    slot = m_n / SLOT;
    slave_pull = m_active && ((slot == 9 && !m_nack1) || (slot == 18 && !m_nack1 && !m_nack2));
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    logic e_scl, e_sda;
    if (chk_en) begin
      if (m_active) exp_bus(e_scl, e_sda);
      else begin
        e_scl = 1'b1;
        e_sda = 1'b1;
      end
      chk("scl", 32'(bus.scl), 32'(e_scl));
      chk("sda_out", 32'(bus.sda_out), 32'(e_sda));
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("ack_err", 32'(bus.ack_err), 32'(m_err));
      if (m_active && m_n == 0) begin
        got_q.delete();
        cap_word = 32'd0;
        cap_cnt  = 0;
      end
      if (!prev_scl && bus.scl) begin
        got_q.push_back(bus.sda_out);
        cap_word = {cap_word[30:0], bus.sda_out};
        cap_cnt++;
      end
      if (m_done) begin
        chk("rise_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
          chk("rise_bit", 32'(got_q[i]), 32'(exp_q[i]));
      end
    end
    prev_scl = bus.scl;
  end

  task automatic run_txn(input logic [6:0] addr, input logic [7:0] data, input bit n1, input bit n2,
                         input int exp_lat, input logic [31:0] exp_bits, input int exp_cnt,
                         input bit exp_err, input bit poke);
    int k;
    bus.slave_addr = addr;
    bus.wr_data    = data;
    next_nack1     = n1;
    next_nack2     = n2;
    cycle(1'b1);
    chk("busy_on_accept", 32'(bus.busy), 32'd1);
    chk("ack_err_clear_on_accept", 32'(bus.ack_err), 32'd0);
    for (k = 0; k < 2000 && !bus.done; k++) begin
      if (poke && k == 37) begin
        bus.slave_addr = ~addr;
        bus.wr_data    = ~data;
        cycle(1'b1);
        bus.slave_addr = addr;
        bus.wr_data    = data;
      end else begin
        cycle(1'b0);
      end
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    chk("ack_err_end", 32'(bus.ack_err), 32'(exp_err));
    if (poke) begin
      bus.slave_addr = ~addr;
      cycle(1'b1);
      chk("busy_after_done_start", 32'(bus.busy), 32'd0);
      bus.slave_addr = addr;
    end
    chk("scl_bits", cap_word, exp_bits);
    chk("scl_rises", 32'(cap_cnt), 32'(exp_cnt));
    cycle(1'b0);
  endtask

  initial begin
    int k;
    bus.start      = 1'b0;
    bus.slave_addr = 7'h00;
    bus.wr_data    = 8'h00;
    next_nack1     = 1'b0;
    next_nack2     = 1'b0;
    cap_word       = 32'd0;
    cap_cnt        = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_scl", 32'(bus.scl), 32'd1);
    chk("reset_sda", 32'(bus.sda_out), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_ack_err", 32'(bus.ack_err), 32'd0);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    cycle(1'b0);
    cycle(1'b0);

    // Directed: both ACKed, with stray starts mid-transfer and in the done cycle.
    run_txn(7'h51, 8'hAE, 1'b0, 1'b0, 320, 32'({8'hA2, 1'b1, 8'hAE, 2'b10}), 19, 1'b0, 1'b1);
    // NACK on the address byte: no data bits, straight to STOP.
    run_txn(7'h51, 8'hAE, 1'b1, 1'b0, 176, 32'({8'hA2, 2'b10}), 10, 1'b1, 1'b0);
    // NACK on the data byte.
    run_txn(7'h51, 8'hAE, 1'b0, 1'b1, 320, 32'({8'hA2, 1'b1, 8'hAE, 2'b10}), 19, 1'b1, 1'b0);
    // Clean transfer after the NACK clears ack_err on acceptance.
    run_txn(7'h51, 8'hAE, 1'b0, 1'b0, 320, 32'({8'hA2, 1'b1, 8'hAE, 2'b10}), 19, 1'b0, 1'b0);

    // Asynchronous reset during DATA bit 4.
    bus.slave_addr = 7'h51;
    bus.wr_data    = 8'hAE;
    next_nack1     = 1'b0;
    next_nack2     = 1'b0;
    cycle(1'b1);
    for (k = 0; k < 2000 && m_n != 13 * SLOT + 5; k++) cycle(1'b0);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_scl", 32'(bus.scl), 32'd1);
    chk("rst_async_sda", 32'(bus.sda_out), 32'd1);
    chk("rst_async_busy", 32'(bus.busy), 32'd0);
    repeat (3) cycle(1'b0);
    #1 rst = 1'b0;
    cycle(1'b0);
    run_txn(7'h51, 8'hAE, 1'b0, 1'b0, 320, 32'({8'hA2, 1'b1, 8'hAE, 2'b10}), 19, 1'b0, 1'b0);

    // Randomized transfers with random NACKs and stray start pulses.
    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(1, 4)) begin
        bus.slave_addr = 7'($urandom);
        bus.wr_data    = 8'($urandom);
        cycle(1'b0);
      end
      next_nack1     = ($urandom_range(0, 3) == 0);
      next_nack2     = ($urandom_range(0, 3) == 0);
      bus.slave_addr = 7'($urandom);
      bus.wr_data    = 8'($urandom);
      cycle(1'b1);
      for (k = 0; k < 2000 && !bus.done; k++) begin
        bus.slave_addr = 7'($urandom);
        bus.wr_data    = 8'($urandom);
        cycle($urandom_range(0, 49) == 0);
      end
      chk("rand_done_seen", 32'(bus.done), 32'd1);
      cycle($urandom_range(0, 1) == 1);
    end

    cycle(1'b0);
    cycle(1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
